mem_access_sequencer: RTL and testbench
=======================================

# mem_access_sequencer

Multi-cycle sequencer and arbiter that shares one byte-wide main memory between the instruction-fetch port and the load/store data port of the single-cycle RISC-V-style datapath. It accepts 32-bit fetches and 8/16/32-bit loads and stores, then issues one byte beat per cycle to memory. Load data is assembled little-endian and sign- or zero-extended; store data is split into byte beats. It sits between the `controller` outputs (`readDataMem`, `WriteDataMem`, `sizeDataMem`) and the byte array.

## Interface
- `ADDR_W`, 8: memory byte-address width; addresses wrap modulo 2^ADDR_W.
- `clk` input 1: clock; all state updates on rising edge.
- `reset` input 1: synchronous, active-high reset.
- `if_req` input 1: fetch request; held until `if_done`.
- `if_addr` input 32: fetch byte address; bits [1:0] are forced to 00, and the low ADDR_W bits are used.
- `if_rdata` output 32: fetched word; valid while `if_done` is 1 and held until the next fetch completes.
- `if_done` output 1: one-cycle completion pulse.
- `dm_req` input 1: data request; held with its fields stable until `dm_done`.
- `dm_we` input 1: 1 for store, 0 for load.
- `dm_size` input 2: 00 byte, 01 half, 10 word, 11 illegal.
- `dm_unsigned` input 1: zero-extends the load when 1 (inst[14]).
- `dm_addr` input 32: data byte address.
- `dm_wdata` input 32: store data; the low 8/16/32 bits are used.
- `dm_rdata` output 32: extended load result; valid while `dm_done` is 1, and 0 after a store or an error.
- `dm_done` output 1: one-cycle completion pulse.
- `dm_err` output 1: pulses together with `dm_done` on an illegal size or a misaligned access.
- `mem_addr` output ADDR_W: byte address of the current beat.
- `mem_wdata` output 8: byte being written.
- `mem_we` output 1: write strobe for the current beat.
- `mem_re` output 1: read strobe for the current beat.
- `mem_rdata` input 8: combinational read data for `mem_addr` in the same cycle.
- `busy` output 1: 1 in every state except IDLE.

## Operation
- States:
  - IDLE → GRANT decision.
  - FETCH_BEAT / LD_BEAT / ST_BEAT: one byte per cycle, beat counter 0..N-1.
  - DONE: one cycle.
- Beat count N: 1, 2 or 4 from `dm_size`; fetches always use N=4.
- Arbitration happens in IDLE only:
  - With one request pending, that request is granted.
  - With both pending, the requester not granted last time wins.
  - `last_grant` resets to fetch, so the data port wins the first tie.
- On grant, the address, size, `dm_we`, `dm_unsigned` and `dm_wdata` are latched. Later changes to the inputs are ignored until DONE.
- Beat k:
  - `mem_addr` = base + k, modulo 2^ADDR_W.
  - Loads and fetches: `mem_re`=1, and `mem_rdata` is captured into byte k of the assembly register.
  - Stores: `mem_we`=1, and `mem_wdata` = latched wdata[8k+7:8k].
- DONE:
  - The done pulse for the granted port is asserted.
  - Load results are sign-extended from bit 7 or 15 unless `dm_unsigned` is set.
  - Next state is IDLE.
- Error: `dm_size`=11 goes from grant straight to DONE with `dm_err`=1. No memory beat is issued and `dm_rdata`=0.
- Outputs in IDLE and DONE: `mem_we`, `mem_re`, `mem_wdata` = 0, and `mem_addr` holds its last value.

## Timing
- Latency, with request seen in IDLE at cycle 0:
  - Beats occupy cycles 1..N.
  - Done pulse in cycle N+1.
  - A new grant is possible at cycle N+2.
  - Word access: 6 cycles request-to-next-grant. Byte access: 3 cycles.
- A request that rises while the sequencer is busy waits. It is evaluated in the first IDLE cycle.
- A request that drops before done is a protocol violation and has undefined results. It does not deadlock: the sequence still completes and pulses done.
- Reset, including mid-operation:
  - Next cycle: state IDLE, all strobes 0, `mem_addr` 0.
  - `if_rdata`/`dm_rdata` are 0, `busy`/`if_done`/`dm_done`/`dm_err` are 0, and `last_grant` is fetch.
  - No done pulse is produced for the aborted access.
  - Bytes already written stay in memory.
- Reset and request asserted in the same cycle: reset wins, and the request is granted in the first cycle after reset deasserts.

## Configuration
- `MEMSEQ_ALIGN_CHECK_EN`:
  - Defined: a half access with addr[0]=1, or a word access with addr[1:0]≠00, is rejected like `dm_size`=11. It costs 2 cycles with `dm_err`=1 and no beats.
  - Undefined: misaligned accesses run byte-by-byte from the exact address, wrapping modulo 2^ADDR_W, and `dm_err` fires only for size 11.

## Test plan
- Word store then load: store 0xDEADBEEF at addr 0x10 → beats write bytes EF,BE,AD,DE to 0x10..0x13 over 4 cycles; load word at 0x10 → `dm_rdata`=0xDEADBEEF on the `dm_done` cycle (6th cycle after request).
- Signed and unsigned byte/half loads: memory 0x20=0x80, 0x21=0xFF; lb 0x20 → 0xFFFFFF80; lbu 0x20 → 0x00000080; lh 0x20 → 0xFFFFFF80; lhu → 0x0000FF80.
- Arbitration: `if_req` and `dm_req` both raised out of reset → data granted first, fetch granted in the cycle after `dm_done`; a second tie goes to data again, because fetch was granted last.
- Errors: `dm_size`=11 → `dm_done`=`dm_err`=1 two cycles after the request, with no `mem_we`/`mem_re`. With `MEMSEQ_ALIGN_CHECK_EN`, a word load at 0x13 gives the same result. Without it, the same load reads bytes 0x13, 0x14, 0x15, 0x16.
- Wrap-around: with `MEMSEQ_ALIGN_CHECK_EN` undefined, a word store at 0xFE → writes land at 0xFE, 0xFF, 0x00, 0x01.
- Reset mid-store: assert `reset` during beat 2 of a word store to 0x40 → next cycle idle with strobes 0 and no `dm_done`; 0x40 and 0x41 are updated, 0x42 and 0x43 are unchanged.

Source files
------------

// File: rtl/mem_access_sequencer.sv
// Purpose : shares one byte-wide memory between instruction fetch and load/store,
//           issuing one byte beat per cycle and assembling/splitting words little-endian.
// Latency : grant in cycle 0, beats in cycles 1..N, done pulse in cycle N+1 (N = 1/2/4, 0 on error).
// Backpressure: requests are held by the requester until done; a request raised while busy
//           waits for the next IDLE cycle, where ties go to the port not granted last time.
// Ports   : clk/reset (sync, active-high); if_* fetch port; dm_* load/store port;
//           mem_* byte-memory beat interface (mem_rdata is combinational for mem_addr); busy.
// Config  : define MEMSEQ_ALIGN_CHECK_EN to reject misaligned half/word data accesses with dm_err.
module mem_access_sequencer #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_done,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [1:0]        dm_size,
  input  logic              dm_unsigned,
  input  logic [31:0]       dm_addr,
  input  logic [31:0]       dm_wdata,
  output logic [31:0]       dm_rdata,
  output logic              dm_done,
  output logic              dm_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH_BEAT,
    LD_BEAT,
    ST_BEAT,
    DONE
  } seqState_t;

  seqState_t state, nextState;

  // Transaction context latched at grant; the requester's inputs are ignored afterwards.
  logic [ADDR_W-1:0] baseAddr;
  logic [ADDR_W-1:0] lastAddr;
  logic [1:0]        sizeQ;
  logic [1:0]        beatCnt;
  logic [1:0]        lastBeat;
  logic              unsQ;
  logic              errQ;
  logic              grantData;
  logic              lastGrantData;
  logic [31:0]       wdataQ;
  logic [31:0]       asmQ;
  logic [31:0]       asmNext;
  logic [31:0]       ifRdataQ;
  logic [31:0]       dmRdataQ;

  logic pickData;
  logic pickFetch;
  logic reqErr;
  logic finalBeat;

  // Only the low ADDR_W address bits reach memory; fetch bits [1:0] are forced to zero.
  logic unusedAddrBits;
  assign unusedAddrBits = ^{if_addr[31:ADDR_W], if_addr[1:0], dm_addr[31:ADDR_W]};

  function automatic logic [31:0] extendLoad(input logic [31:0] raw,
                                             input logic [1:0]  size,
                                             input logic        uns);
    case (size)
      2'b00:   extendLoad = uns ? {24'h0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
      2'b01:   extendLoad = uns ? {16'h0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: extendLoad = raw;
    endcase
  endfunction

  // Arbitration: a lone request wins; on a tie the port not granted last time wins.
  always_comb begin
    pickData  = dm_req && (!if_req || !lastGrantData);
    pickFetch = if_req && !pickData;
    reqErr    = (dm_size == 2'b11);
`ifdef MEMSEQ_ALIGN_CHECK_EN
    if ((dm_size == 2'b01 && dm_addr[0]) ||
        (dm_size == 2'b10 && dm_addr[1:0] != 2'b00)) begin
      reqErr = 1'b1;
    end
`endif
  end

  assign finalBeat = (beatCnt == lastBeat);

  // Current assembly word with the byte arriving on this beat merged in, so the last
  // beat can publish the full result straight into the output registers.
  always_comb begin
    asmNext = asmQ;
    asmNext[{beatCnt, 3'b000} +: 8] = mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_wdata = 8'h00;
    mem_addr  = lastAddr;
    if_done   = 1'b0;
    dm_done   = 1'b0;
    dm_err    = 1'b0;
    case (state)
      IDLE: begin
        if (pickData) begin
          if (reqErr) begin
            nextState = DONE;
          end else if (dm_we) begin
            nextState = ST_BEAT;
          end else begin
            nextState = LD_BEAT;
          end
        end else if (pickFetch) begin
          nextState = FETCH_BEAT;
        end
      end
      FETCH_BEAT, LD_BEAT: begin
        mem_re   = 1'b1;
        mem_addr = baseAddr + ADDR_W'(beatCnt);
        if (finalBeat) nextState = DONE;
      end
      ST_BEAT: begin
        mem_we    = 1'b1;
        mem_addr  = baseAddr + ADDR_W'(beatCnt);
        mem_wdata = wdataQ[{beatCnt, 3'b000} +: 8];
        if (finalBeat) nextState = DONE;
      end
      DONE: begin
        nextState = IDLE;
        if_done   = !grantData;
        dm_done   = grantData;
        dm_err    = grantData && errQ;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      baseAddr      <= '0;
      lastAddr      <= '0;
      sizeQ         <= 2'b00;
      beatCnt       <= 2'b00;
      lastBeat      <= 2'b00;
      unsQ          <= 1'b0;
      errQ          <= 1'b0;
      grantData     <= 1'b0;
      lastGrantData <= 1'b0;
      wdataQ        <= 32'h0;
      asmQ          <= 32'h0;
      ifRdataQ      <= 32'h0;
      dmRdataQ      <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (pickData) begin
            grantData     <= 1'b1;
            lastGrantData <= 1'b1;
            baseAddr      <= dm_addr[ADDR_W-1:0];
            sizeQ         <= dm_size;
            unsQ          <= dm_unsigned;
            wdataQ        <= dm_wdata;
            errQ          <= reqErr;
            beatCnt       <= 2'b00;
            asmQ          <= 32'h0;
            case (dm_size)
              2'b00:   lastBeat <= 2'd0;
              2'b01:   lastBeat <= 2'd1;
              default: lastBeat <= 2'd3;
            endcase
            // Stores and rejected accesses report zero load data.
            if (reqErr || dm_we) dmRdataQ <= 32'h0;
          end else if (pickFetch) begin
            grantData     <= 1'b0;
            lastGrantData <= 1'b0;
            baseAddr      <= {if_addr[ADDR_W-1:2], 2'b00};
            errQ          <= 1'b0;
            beatCnt       <= 2'b00;
            lastBeat      <= 2'd3;
            asmQ          <= 32'h0;
          end
        end
        FETCH_BEAT, LD_BEAT, ST_BEAT: begin
          lastAddr <= mem_addr;
          beatCnt  <= beatCnt + 2'd1;
          if (state != ST_BEAT) asmQ <= asmNext;
          if (finalBeat && state == FETCH_BEAT) ifRdataQ <= asmNext;
          if (finalBeat && state == LD_BEAT)    dmRdataQ <= extendLoad(asmNext, sizeQ, unsQ);
        end
        default: ;
      endcase
    end
  end

  assign if_rdata = ifRdataQ;
  assign dm_rdata = dmRdataQ;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_mem_access_sequencer.sv
module tb_mem_access_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        dm_req;
  logic        dm_we;
  logic [1:0]  dm_size;
  logic        dm_unsigned;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_done;
  logic        dm_err;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [7:0]  mem_rdata;
  logic        busy;

  always #5 clk = ~clk;

  mem_access_sequencer #(.ADDR_W(8)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .dm_req(dm_req), .dm_we(dm_we), .dm_size(dm_size), .dm_unsigned(dm_unsigned),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
    .dm_done(dm_done), .dm_err(dm_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // Byte memory driven by the DUT, and the reference image updated per transaction.
  logic [7:0] mem [256];
  logic [7:0] refMem [256];
  logic       memClr;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (memClr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 7 + 3);
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  // Beat monitor.
  logic [7:0] beatQ [$];
  int weCnt;
  int reCnt;
  always @(negedge clk) begin
    if (mem_we || mem_re) begin
      beatQ.push_back(mem_addr);
      if (mem_we) weCnt++;
      if (mem_re) reCnt++;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] refWord(input logic [7:0] a);
    logic [7:0] b;
    b = {a[7:2], 2'b00};
    return {refMem[8'(b + 3)], refMem[8'(b + 2)], refMem[8'(b + 1)], refMem[b]};
  endfunction

  // Data access: caller is at a negedge in an IDLE cycle.
  task automatic dataOp(input string tag, input logic we, input logic [1:0] sz,
                        input logic uns, input logic [7:0] addr, input logic [31:0] wd);
    int n, cyc, badAddr;
    logic expErr;
    logic [31:0] raw, expRd;
    expErr = (sz == 2'b11);
`ifdef MEMSEQ_ALIGN_CHECK_EN
    if ((sz == 2'b01 && addr[0]) || (sz == 2'b10 && addr[1:0] != 2'b00)) expErr = 1'b1;
`endif
    n = expErr ? 0 : (1 << sz);
    raw = 32'h0;
    for (int k = 0; k < n; k++) raw[8*k +: 8] = refMem[8'(addr + k)];
    expRd = 32'h0;
    if (!we && !expErr) begin
      expRd = raw;
      if (!uns && sz == 2'b00 && raw[7])  expRd = raw | 32'hFFFF_FF00;
      if (!uns && sz == 2'b01 && raw[15]) expRd = raw | 32'hFFFF_0000;
    end
    if (we) for (int k = 0; k < n; k++) refMem[8'(addr + k)] = wd[8*k +: 8];

    dm_we = we; dm_size = sz; dm_unsigned = uns;
    dm_addr = {24'($urandom), addr}; dm_wdata = wd;
    beatQ.delete(); weCnt = 0; reCnt = 0;
    dm_req = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!dm_done && cyc < 20);
    dm_req = 1'b0;
    checkVal({tag, " latency"}, cyc, n + 1);
    checkVal({tag, " rdata"}, dm_rdata, expRd);
    checkVal({tag, " err"}, {31'h0, dm_err}, {31'h0, expErr});
    checkVal({tag, " beats"}, we ? weCnt : reCnt, n);
    checkVal({tag, " stray strobes"}, we ? reCnt : weCnt, 0);
    badAddr = 0;
    for (int k = 0; k < beatQ.size(); k++) if (beatQ[k] != 8'(addr + k)) badAddr++;
    checkVal({tag, " beat addrs"}, badAddr, 0);
  endtask

  task automatic fetchOp(input string tag, input logic [7:0] addr);
    int cyc, badAddr;
    logic [7:0] b;
    logic [31:0] expW;
    b = {addr[7:2], 2'b00};
    expW = refWord(addr);
    if_addr = {24'($urandom), addr};
    beatQ.delete(); weCnt = 0; reCnt = 0;
    if_req = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!if_done && cyc < 20);
    if_req = 1'b0;
    checkVal({tag, " latency"}, cyc, 5);
    checkVal({tag, " rdata"}, if_rdata, expW);
    checkVal({tag, " reads"}, reCnt, 4);
    checkVal({tag, " writes"}, weCnt, 0);
    badAddr = 0;
    for (int k = 0; k < beatQ.size(); k++) if (beatQ[k] != 8'(b + k)) badAddr++;
    checkVal({tag, " beat addrs"}, badAddr, 0);
  endtask

  // Both ports request at once; the data port (unsigned byte load) must win, and the
  // fetch is granted in the cycle right after the data done pulse.
  task automatic tieOp(input string tag, input logic [7:0] da, input logic [7:0] fa);
    int cyc, dmAt, ifAt;
    logic [31:0] dmGot, ifGot, expW;
    expW = refWord(fa);
    dm_we = 1'b0; dm_size = 2'b00; dm_unsigned = 1'b1; dm_addr = {24'h0, da};
    if_addr = {24'h0, fa};
    dm_req = 1'b1; if_req = 1'b1;
    cyc = 0; dmAt = -1; ifAt = -1; dmGot = 32'h0; ifGot = 32'h0;
    while ((dmAt < 0 || ifAt < 0) && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (dm_done && dmAt < 0) begin dmAt = cyc; dmGot = dm_rdata; dm_req = 1'b0; end
      if (if_done && ifAt < 0) begin ifAt = cyc; ifGot = if_rdata; if_req = 1'b0; end
    end
    dm_req = 1'b0; if_req = 1'b0;
    checkVal({tag, " data done cycle"}, dmAt, 2);
    checkVal({tag, " fetch done cycle"}, ifAt, 8);
    checkVal({tag, " data value"}, dmGot, {24'h0, refMem[da]});
    checkVal({tag, " fetch value"}, ifGot, expW);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [31:0] w;
    int mism;
    for (int i = 0; i < 256; i++) refMem[i] = 8'(i * 7 + 3);
    reset = 1'b1; memClr = 1'b1;
    if_req = 1'b0; if_addr = 32'h0;
    dm_req = 1'b0; dm_we = 1'b0; dm_size = 2'b00; dm_unsigned = 1'b0;
    dm_addr = 32'h0; dm_wdata = 32'h0;
    weCnt = 0; reCnt = 0;
    repeat (2) @(negedge clk);
    memClr = 1'b0;
    checkVal("reset busy", {31'h0, busy}, 0);
    checkVal("reset strobes", {30'h0, mem_we, mem_re}, 0);
    checkVal("reset mem_addr", {24'h0, mem_addr}, 0);
    checkVal("reset dones", {29'h0, if_done, dm_done, dm_err}, 0);
    checkVal("reset if_rdata", if_rdata, 0);
    checkVal("reset dm_rdata", dm_rdata, 0);
    reset = 1'b0;

    @(negedge clk); tieOp("tie1", 8'h05, 8'h09);
    @(negedge clk); tieOp("tie2", 8'h33, 8'h60);

    // Word store/load round trip.
    w = 32'hDEADBEEF;
    @(negedge clk); dataOp("sw 0x10", 1'b1, 2'b10, 1'b0, 8'h10, w);
    for (int k = 0; k < 4; k++) checkVal("sw byte", {24'h0, mem[8'(8'h10 + k)]}, {24'h0, w[8*k +: 8]});
    @(negedge clk); dataOp("lw 0x10", 1'b0, 2'b10, 1'b0, 8'h10, 32'h0);
    checkVal("lw value", dm_rdata, 32'hDEADBEEF);

    // Sign/zero extension.
    @(negedge clk); dataOp("sh 0x20", 1'b1, 2'b01, 1'b0, 8'h20, 32'h1234FF80);
    @(negedge clk); dataOp("lb 0x20", 1'b0, 2'b00, 1'b0, 8'h20, 32'h0);
    checkVal("lb value", dm_rdata, 32'hFFFFFF80);
    @(negedge clk); dataOp("lbu 0x20", 1'b0, 2'b00, 1'b1, 8'h20, 32'h0);
    @(negedge clk); dataOp("lh 0x20", 1'b0, 2'b01, 1'b0, 8'h20, 32'h0);
    @(negedge clk); dataOp("lhu 0x20", 1'b0, 2'b01, 1'b1, 8'h20, 32'h0);
    checkVal("lhu value", dm_rdata, 32'h0000FF80);

    // Errors, misalignment and wrap-around.
    @(negedge clk); dataOp("size11 ld", 1'b0, 2'b11, 1'b0, 8'h20, 32'h0);
    @(negedge clk); dataOp("size11 st", 1'b1, 2'b11, 1'b0, 8'h24, 32'hCAFEF00D);
    @(negedge clk); dataOp("lw 0x13", 1'b0, 2'b10, 1'b0, 8'h13, 32'h0);
    @(negedge clk); dataOp("sw 0xFE wrap", 1'b1, 2'b10, 1'b0, 8'hFE, 32'hA1B2C3D4);
    @(negedge clk); dataOp("lh 0xFF", 1'b0, 2'b01, 1'b0, 8'hFF, 32'h0);

    @(negedge clk); fetchOp("fetch 0x10", 8'h12);
    @(negedge clk); fetchOp("fetch 0xFC", 8'hFD);

    // Reset during beat 2 of a word store to 0x40.
    @(negedge clk);
    dm_we = 1'b1; dm_size = 2'b10; dm_unsigned = 1'b0;
    dm_addr = 32'h40; dm_wdata = 32'h11223344; dm_req = 1'b1;
    refMem[8'h40] = 8'h44; refMem[8'h41] = 8'h33;
    repeat (2) @(negedge clk);
    checkVal("mid-store busy", {31'h0, busy}, 1);
    reset = 1'b1; dm_req = 1'b0;
    @(negedge clk);
    checkVal("rst busy", {31'h0, busy}, 0);
    checkVal("rst strobes", {30'h0, mem_we, mem_re}, 0);
    checkVal("rst mem_addr", {24'h0, mem_addr}, 0);
    checkVal("rst dones", {29'h0, if_done, dm_done, dm_err}, 0);
    checkVal("rst if_rdata", if_rdata, 0);
    checkVal("rst dm_rdata", dm_rdata, 0);
    for (int k = 0; k < 4; k++)
      checkVal("rst mem bytes", {24'h0, mem[8'(8'h40 + k)]}, {24'h0, refMem[8'(8'h40 + k)]});
    // Request raised while reset is still held: granted once reset drops.
    dm_we = 1'b0; dm_size = 2'b00; dm_unsigned = 1'b1; dm_addr = 32'h41; dm_req = 1'b1;
    @(negedge clk);
    checkVal("rst+req idle", {31'h0, busy}, 0);
    reset = 1'b0;
    dataOp("lbu after rst", 1'b0, 2'b00, 1'b1, 8'h41, 32'h0);

    // Randomized traffic against the reference image.
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 4) == 0) fetchOp("rnd fetch", 8'($urandom));
      else dataOp("rnd data", 1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
                  8'($urandom), $urandom);
    end

    mism = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== refMem[i]) mism++;
    checkVal("memory image", mism, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
